// File: rtl/if_fetch_bp.sv
// Instruction fetch stage with static JAL prediction, a 2-bit-counter BHT for
// conditional branches, and a small instruction FIFO toward the decoder.
// One fetch is outstanding at a time; a ROB redirect flushes the FIFO and
// drops any response still in flight.
module if_fetch_bp #(
  parameter int          QUEUE_DEPTH = 4,
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jp_wrong,
  input  logic [31:0] jp_pc,
  input  logic        bht_upd_en,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken,
  output logic        ic_req,
  output logic [31:0] ic_pc,
  input  logic        ic_rsp_valid,
  input  logic [31:0] ic_ins,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_pc
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int BW = $clog2(BHT_ENTRIES);
  localparam logic [QW:0] DEPTH_C = QUEUE_DEPTH[QW:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
  endfunction

  // Predecode one instruction: returns {pred_taken, pred_pc}.
  function automatic logic [32:0] predict(input logic [31:0] ins, input logic [31:0] fpc,
                                          input logic bht_taken);
    logic signed [31:0] imm_j;
    logic signed [31:0] imm_b;
    logic        [31:0] seq_pc;
    imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    seq_pc = fpc + 32'd4;
    case (ins[6:0])
      OP_JAL:    predict = {1'b1, fpc + $unsigned(imm_j)};
      OP_BRANCH: predict = bht_taken ? {1'b1, fpc + $unsigned(imm_b)} : {1'b0, seq_pc};
      default:   predict = {1'b0, seq_pc};
    endcase
  endfunction

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [QW-1:0] wr_ptr;
  logic [QW-1:0] rd_ptr;
  logic [QW:0]   count;

  logic [31:0] q_ins     [QUEUE_DEPTH];
  logic [31:0] q_pc      [QUEUE_DEPTH];
  logic [31:0] q_pred_pc [QUEUE_DEPTH];
  logic        q_taken   [QUEUE_DEPTH];

  logic [1:0]  bht [BHT_ENTRIES];

  logic          issue;
  logic          pop;
  logic          vld_p0;
  logic          pred_taken_p0;
  logic [31:0]   pred_pc_p0;
  logic [BW-1:0] bht_idx_p0;
  logic [BW-1:0] upd_idx;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^{bht_upd_pc[31:BW+2], bht_upd_pc[1:0]};

  assign issue  = rdy && !rst && !jp_wrong && (state == S_IDLE) && (count < DEPTH_C);
  assign ic_req = issue;
  assign ic_pc  = pc;

  // Fetch response -> predecoded FIFO entry (p0 = response cycle)
  assign bht_idx_p0 = pc[BW+1:2];
  assign upd_idx    = bht_upd_pc[BW+1:2];
  assign {pred_taken_p0, pred_pc_p0} = predict(ic_ins, pc, bht[bht_idx_p0][1]);
  assign vld_p0 = rdy && !jp_wrong && (state == S_WAIT) && ic_rsp_valid;

  assign id_valid = (count != '0);
  assign pop      = rdy && !jp_wrong && id_valid && id_ready;

  // Fetch FSM and PC: redirect wins over everything except reset and freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else if (rdy) begin
      if (jp_wrong) begin
        pc <= jp_pc;
        if (state == S_WAIT) begin
          state <= ic_rsp_valid ? S_IDLE : S_DROP;
        end
      end else begin
        case (state)
          S_IDLE: if (issue) state <= S_WAIT;
          S_WAIT: if (ic_rsp_valid) begin
            state <= S_IDLE;
            pc    <= pred_pc_p0;
          end
          S_DROP: if (ic_rsp_valid) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (jp_wrong) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (vld_p0) wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        case ({vld_p0, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage (p1 = buffered toward decoder); data needs no reset.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      q_ins[wr_ptr]     <= ic_ins;
      q_pc[wr_ptr]      <= pc;
      q_pred_pc[wr_ptr] <= pred_pc_p0;
      q_taken[wr_ptr]   <= pred_taken_p0;
    end
  end

  // Branch history counters, trained by committed branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (rdy && bht_upd_en) begin
      bht[upd_idx] <= sat_update(bht[upd_idx], bht_upd_taken);
    end
  end

  // Head entry presented to the decoder; zero while empty.
  always_comb begin
    id_ins        = '0;
    id_pc         = '0;
    id_pred_pc    = '0;
    id_pred_taken = 1'b0;
    if (id_valid) begin
      id_ins        = q_ins[rd_ptr];
      id_pc         = q_pc[rd_ptr];
      id_pred_pc    = q_pred_pc[rd_ptr];
      id_pred_taken = q_taken[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_fetch_bp.sv
// Randomized bench for if_fetch_bp: an ICache model answers requests with
// generated instructions, a reference model predicts each entry and the next
// fetch PC, and a negedge monitor checks requests and the decoder-side queue.
module tb_if_fetch_bp;
  localparam int DEPTH = 4;
  localparam int BHTN  = 64;
  localparam int NCYC  = 3000;

  logic        clk = 1'b0;
  logic        rst, rdy, jp_wrong;
  logic [31:0] jp_pc;
  logic        bht_upd_en;
  logic [31:0] bht_upd_pc;
  logic        bht_upd_taken;
  logic        ic_req;
  logic [31:0] ic_pc;
  logic        ic_rsp_valid;
  logic [31:0] ic_ins;
  logic        id_ready, id_valid;
  logic [31:0] id_ins, id_pc;
  logic        id_pred_taken;
  logic [31:0] id_pred_pc;

  always #5 clk = ~clk;

  if_fetch_bp #(.QUEUE_DEPTH(DEPTH), .BHT_ENTRIES(BHTN), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong), .jp_pc(jp_pc),
    .bht_upd_en(bht_upd_en), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
    .ic_req(ic_req), .ic_pc(ic_pc), .ic_rsp_valid(ic_rsp_valid), .ic_ins(ic_ins),
    .id_ready(id_ready), .id_valid(id_valid), .id_ins(id_ins), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .id_pred_pc(id_pred_pc)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] nxt;
  } entry_t;

  entry_t      exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;
  int          bht_m[BHTN];
  bit          out_valid, out_drop, run;
  int          out_cnt, max_delay, push_pending, rst_age;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int imm);
    logic [31:0] u;
    u = imm;
    return {u[20], u[10:1], u[11], u[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int imm);
    logic [31:0] u;
    u = imm;
    return {u[12], u[10:5], 5'd2, 5'd3, 3'b000, u[4:1], u[11], 7'b1100011};
  endfunction

  function automatic int bidx(input logic [31:0] p);
    return int'((p >> 2) % BHTN);
  endfunction

  // kind: 0 = JAL, 1 = conditional branch, 2 = other (incl. JALR)
  function automatic entry_t model_entry(input logic [31:0] ins, input logic [31:0] p,
                                         input int kind, input int imm);
    entry_t e;
    e.ins = ins;
    e.pc  = p;
    if (kind == 0 || (kind == 1 && bht_m[bidx(p)] >= 2)) begin
      e.taken = 1'b1;
      e.nxt   = p + 32'(imm);
    end else begin
      e.taken = 1'b0;
      e.nxt   = p + 32'd4;
    end
    return e;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    model_pc  = 32'h0;
    out_valid = 0;
    out_drop  = 0;
    out_cnt   = 0;
    for (int i = 0; i < BHTN; i++) bht_m[i] = 1;
  endtask

  // Monitor: request pulses and decoder-side head entry against the model.
  always @(negedge clk) begin
    int occ;
    bit exp_req;
    if (run) begin
      if (rst) begin
        check("ic_req_in_reset", 32'(ic_req), 32'd0);
        if (rst_age > 0) begin
          check("rst_id_valid", 32'(id_valid), 32'd0);
          check("rst_id_ins", id_ins, 32'd0);
          check("rst_id_pc", id_pc, 32'd0);
          check("rst_id_pred_taken", 32'(id_pred_taken), 32'd0);
          check("rst_id_pred_pc", id_pred_pc, 32'd0);
        end
      end else begin
        occ     = exp_q.size() - push_pending;
        exp_req = rdy && !jp_wrong && !out_valid && !ic_rsp_valid && (occ < DEPTH);
        check("ic_req", 32'(ic_req), 32'(exp_req));
        if (ic_req && exp_req) begin
          check("ic_pc", ic_pc, model_pc);
          out_valid = 1;
          out_drop  = 0;
          out_cnt   = $urandom_range(1, max_delay);
        end
        if (!jp_wrong) begin
          check("id_valid", 32'(id_valid), 32'(occ > 0));
          if (id_valid && occ > 0) begin
            check("id_ins", id_ins, exp_q[0].ins);
            check("id_pc", id_pc, exp_q[0].pc);
            check("id_pred_taken", 32'(id_pred_taken), 32'(exp_q[0].taken));
            check("id_pred_pc", id_pred_pc, exp_q[0].nxt);
            if (rdy && id_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Stimulus: ICache responses, redirects, BHT training, flow control.
  initial begin
    entry_t      e;
    logic [31:0] ins;
    int          kind, imm, t, phase;
    bit          fire, jp;
    rst = 1; rdy = 1; jp_wrong = 0; jp_pc = 0;
    bht_upd_en = 0; bht_upd_pc = 0; bht_upd_taken = 0;
    ic_rsp_valid = 0; ic_ins = 0; id_ready = 0;
    model_reset();
    max_delay = 1; push_pending = 0; rst_age = 0; run = 1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      jp_wrong = 0; bht_upd_en = 0; ic_rsp_valid = 0; push_pending = 0;
      if (cyc < 3 || (cyc >= 1500 && cyc < 1502)) begin
        rst_age = rst ? rst_age + 1 : 0;
        rst = 1; rdy = 1; id_ready = 0;
        model_reset();
        continue;
      end
      rst = 0;
      if (cyc < 300)      phase = 1;
      else if (cyc < 600) phase = 2;
      else                phase = 3;
      case (phase)
        1: begin rdy = 1; id_ready = ($urandom_range(0, 3) != 0); max_delay = 1; end
        2: begin rdy = 1; id_ready = ($urandom_range(0, 9) == 0); max_delay = 2; end
        default: begin
          rdy = ($urandom_range(0, 7) != 0); id_ready = ($urandom_range(0, 9) < 6); max_delay = 3;
        end
      endcase

      fire = 0;
      if (out_valid) begin
        if (out_cnt > 0) out_cnt--;
        if (out_cnt == 0 && rdy) fire = 1;
      end
      jp = (phase == 3) && rdy && ($urandom_range(0, 24) == 0) && !(fire && out_drop);

      if (fire) begin
        kind = $urandom_range(0, 9);
        if (kind < 3) begin
          if ($urandom_range(0, 3) == 0) begin t = $urandom_range(0, 1048575); imm = (t - 524288) * 2; end
          else begin t = $urandom_range(0, 255); imm = (t - 128) * 2; end
          ins = enc_jal(imm); kind = 0;
        end else if (kind < 7) begin
          t = $urandom_range(0, 4095); imm = (t - 2048) * 2;
          ins = enc_br(imm); kind = 1;
        end else begin
          ins = $urandom;
          ins[6:0] = (kind == 7) ? 7'b1100111 : 7'b0010011;
          imm = 0; kind = 2;
        end
        ic_ins = ins;
        ic_rsp_valid = 1;
        if (!out_drop && !jp) begin
          e = model_entry(ins, model_pc, kind, imm);
          exp_q.push_back(e);
          model_pc = e.nxt;
          push_pending = 1;
        end
        out_valid = 0;
        out_drop  = 0;
      end

      if (jp) begin
        jp_wrong = 1;
        jp_pc = 32'($urandom_range(0, 1023)) << 2;
        exp_q.delete();
        model_pc = jp_pc;
        push_pending = 0;
        if (out_valid) out_drop = 1;
      end

      if (rdy && $urandom_range(0, 9) < 3) begin
        bht_upd_en    = 1;
        bht_upd_pc    = $urandom;
        bht_upd_taken = ($urandom_range(0, 9) < 7);
        t = bidx(bht_upd_pc);
        if (bht_upd_taken) bht_m[t] = (bht_m[t] == 3) ? 3 : bht_m[t] + 1;
        else               bht_m[t] = (bht_m[t] == 0) ? 0 : bht_m[t] - 1;
      end
    end

    @(posedge clk); #1;
    run = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
